trap_unit: RTL and testbench

TRAP_UNIT -- requirements
Module: trap_unit

---
 rtl/trap_unit.sv | 216 +++++++++++++++++++++
 tb/tb_trap_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap / mret sequencer.
// It selects an exception, an interrupt or an mret from decode. It then
// issues the CSR writes one per cycle through a single write port, and
// finishes with a one-cycle fetch redirect.
// Optional feature: define TRAP_UNIT_MTVAL_EN to add an mtval write step
// after mcause (the redirect then moves one cycle later).
module trap_unit #(
  parameter int XLEN        = 64,
  parameter bit RST_PC_HOLD = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_pc_i,
  input  logic [3:0]      expt_i,
  input  logic [31:0]     inst_i,
  input  logic [2:0]      irq_i,
  input  logic [2:0]      mie_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            hold_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
`ifdef TRAP_UNIT_MTVAL_EN
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET
`ifdef TRAP_UNIT_MTVAL_EN
    , S_MTVAL
`endif
  } state_t;

  state_t state, state_n;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1, MPP stays M.
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] cause_word(input logic intr, input logic [3:0] code);
    logic [XLEN-1:0] r;
    r           = '0;
    r[XLEN-1]   = intr;
    r[3:0]      = code;
    return r;
  endfunction

  // Vectored mode applies only to interrupts; modes 2/3 fall back to direct.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic intr, input logic [3:0] code);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (tvec[1:0] == 2'b01 && intr) return base + XLEN'({code, 2'b00});
    return base;
  endfunction

  logic [2:0]      irq_elig;
  logic            sel_trap, sel_mret, sel_intr;
  logic [3:0]      sel_code;
  logic [XLEN-1:0] mepc_p0;
  logic [3:0]      cause_p0;
  logic            intr_p0;
  logic            first_p0;
  logic            wen_n, rv_n;
  logic [11:0]     waddr_n;
  logic [XLEN-1:0] wdata_n, rpc_n;
`ifdef TRAP_UNIT_MTVAL_EN
  logic [XLEN-1:0] mtval_p0;
`else
  logic            unused_inst;
  assign unused_inst = ^inst_i;
`endif

  assign irq_elig = {3{mstatus_i[3]}} & irq_i & mie_i;

  // Priority select of the pending event seen at decode.
  always_comb begin
    sel_trap = 1'b0;
    sel_mret = 1'b0;
    sel_intr = 1'b0;
    sel_code = 4'd0;
    if (expt_i[3])        begin sel_trap = 1'b1; sel_code = 4'd2;  end
    else if (expt_i[2])   begin sel_trap = 1'b1; sel_code = 4'd11; end
    else if (expt_i[1])   begin sel_trap = 1'b1; sel_code = 4'd3;  end
    else if (irq_elig[2]) begin sel_trap = 1'b1; sel_intr = 1'b1; sel_code = 4'd11; end
    else if (irq_elig[1]) begin sel_trap = 1'b1; sel_intr = 1'b1; sel_code = 4'd3;  end
    else if (irq_elig[0]) begin sel_trap = 1'b1; sel_intr = 1'b1; sel_code = 4'd7;  end
    else if (expt_i[0])   sel_mret = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and next registered CSR-write / redirect values.
  always_comb begin
    state_n = state;
    wen_n   = 1'b0;
    waddr_n = '0;
    wdata_n = '0;
    rv_n    = 1'b0;
    rpc_n   = '0;
    unique case (state)
      S_IDLE: begin
        if (sel_trap)      state_n = S_MEPC;
        else if (sel_mret) state_n = S_MRET;
      end
      S_MEPC: begin
        wen_n = 1'b1; waddr_n = ADDR_MEPC; wdata_n = mepc_p0;
        state_n = S_MSTATUS;
      end
      S_MSTATUS: begin
        wen_n = 1'b1; waddr_n = ADDR_MSTATUS; wdata_n = trap_mstatus(mstatus_i);
        state_n = S_MCAUSE;
      end
      S_MCAUSE: begin
        wen_n = 1'b1; waddr_n = ADDR_MCAUSE; wdata_n = cause_word(intr_p0, cause_p0);
`ifdef TRAP_UNIT_MTVAL_EN
        state_n = S_MTVAL;
`else
        rv_n = 1'b1; rpc_n = trap_target(mtvec_i, intr_p0, cause_p0);
        state_n = S_IDLE;
`endif
      end
`ifdef TRAP_UNIT_MTVAL_EN
      S_MTVAL: begin
        wen_n = 1'b1; waddr_n = ADDR_MTVAL; wdata_n = mtval_p0;
        rv_n = 1'b1; rpc_n = trap_target(mtvec_i, intr_p0, cause_p0);
        state_n = S_IDLE;
      end
`endif
      S_MRET: begin
        wen_n = 1'b1; waddr_n = ADDR_MSTATUS; wdata_n = mret_mstatus(mstatus_i);
        rv_n = 1'b1; rpc_n = mepc_i;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Capture trap context when leaving IDLE for a trap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mepc_p0  <= '0;
      cause_p0 <= '0;
      intr_p0  <= 1'b0;
`ifdef TRAP_UNIT_MTVAL_EN
      mtval_p0 <= '0;
`endif
    end else if (state == S_IDLE && sel_trap) begin
      mepc_p0  <= (sel_intr && jump_i) ? jump_pc_i : pc_i;
      cause_p0 <= sel_code;
      intr_p0  <= sel_intr;
`ifdef TRAP_UNIT_MTVAL_EN
      if (!sel_intr && sel_code == 4'd2)      mtval_p0 <= XLEN'(inst_i);
      else if (!sel_intr && sel_code == 4'd3) mtval_p0 <= pc_i;
      else                                    mtval_p0 <= '0;
`endif
    end
  end

  // Registered CSR write port and redirect; cleared by reset mid-sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csr_wen_o        <= 1'b0;
      csr_waddr_o      <= '0;
      csr_wdata_o      <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      csr_wen_o        <= wen_n;
      csr_waddr_o      <= waddr_n;
      csr_wdata_o      <= wdata_n;
      redirect_valid_o <= rv_n;
      redirect_pc_o    <= rpc_n;
    end
  end

  // Flags the first cycle after reset release for the optional post-reset stall.
  always_ff @(posedge clk) begin
    first_p0 <= !rst_n;
  end

  assign hold_o = (state == S_IDLE && (sel_trap || sel_mret)) || (state != S_IDLE) ||
                  (RST_PC_HOLD && rst_n && first_p0);

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: randomized and directed checks of trap_unit against a
// table-driven reference model of the trap/mret CSR-write schedule.
module tb_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc, jpc, mstatus, mtvec, mepc;
  logic        jump;
  logic [3:0]  expt;
  logic [31:0] inst;
  logic [2:0]  irq, mie;
  logic        csr_wen, rv, hold;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata, rpc;

  int n_checks = 0;
  int n_fail   = 0;

  trap_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .jump_i(jump), .jump_pc_i(jpc),
    .expt_i(expt), .inst_i(inst), .irq_i(irq), .mie_i(mie),
    .mstatus_i(mstatus), .mtvec_i(mtvec), .mepc_i(mepc),
    .csr_wen_o(csr_wen), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .hold_o(hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Caller sets inputs at a negedge (cycle 0); the model predicts cycles 0..7
  // and event inputs are dropped after cycle 0 so exactly one event occurs.
  task automatic run_txn(input string name);
    logic        e_wen[8], e_rv[8], e_hold[8];
    logic [11:0] e_addr[8];
    logic [63:0] e_data[8], e_rpc[8];
    logic [11:0] aq[$];
    logic [63:0] dq[$];
    logic [2:0]  elig;
    logic        cond[7];
    int          codes[7];
    logic        isint[7];
    int          pick;
    logic [63:0] mcap, ms_t, ms_r, cause, tgt, base;
    for (int c = 0; c < 8; c++) begin
      e_wen[c] = 0; e_rv[c] = 0; e_hold[c] = 0; e_addr[c] = 0; e_data[c] = 0; e_rpc[c] = 0;
    end
    elig  = mstatus[3] ? (irq & mie) : 3'b000;
    cond  = '{expt[3], expt[2], expt[1], elig[2], elig[1], elig[0], expt[0]};
    codes = '{2, 11, 3, 11, 3, 7, 0};
    isint = '{0, 0, 0, 1, 1, 1, 0};
    pick = -1;
    for (int i = 0; i < 7; i++) if (pick < 0 && cond[i]) pick = i;
    ms_t = (mstatus & ~64'h1888) | (64'(mstatus[3]) << 7) | 64'h1800;
    ms_r = (mstatus & ~64'h1888) | (64'(mstatus[7]) << 3) | 64'h1880;
    tgt = 0;
    if (pick >= 0 && pick < 6) begin
      mcap  = (isint[pick] && jump) ? jpc : pc;
      cause = (isint[pick] ? 64'h8000_0000_0000_0000 : 64'h0) + 64'(codes[pick]);
      base  = mtvec & ~64'h3;
      tgt   = (mtvec[1:0] == 2'b01 && isint[pick]) ? base + 64'(4 * codes[pick]) : base;
      aq.push_back(12'h341); dq.push_back(mcap);
      aq.push_back(12'h300); dq.push_back(ms_t);
      aq.push_back(12'h342); dq.push_back(cause);
`ifdef TRAP_UNIT_MTVAL_EN
      aq.push_back(12'h343);
      dq.push_back(pick == 0 ? {32'h0, inst} : (pick == 2 ? pc : 64'h0));
`endif
    end else if (pick == 6) begin
      aq.push_back(12'h300); dq.push_back(ms_r);
      tgt = mepc;
    end
    if (aq.size() > 0) begin
      for (int i = 0; i < aq.size(); i++) begin
        e_wen[2+i] = 1; e_addr[2+i] = aq[i]; e_data[2+i] = dq[i];
      end
      e_rv[1+aq.size()]  = 1;
      e_rpc[1+aq.size()] = tgt;
      for (int c = 0; c <= aq.size(); c++) e_hold[c] = 1;
    end
    #1;
    check($sformatf("%s hold c0", name), 64'(hold), 64'(e_hold[0]));
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin expt = 0; irq = 0; jump = 0; end
      #1;
      check($sformatf("%s wen c%0d", name, k), 64'(csr_wen), 64'(e_wen[k]));
      check($sformatf("%s addr c%0d", name, k), 64'(csr_waddr), 64'(e_addr[k]));
      check($sformatf("%s data c%0d", name, k), csr_wdata, e_data[k]);
      check($sformatf("%s rv c%0d", name, k), 64'(rv), 64'(e_rv[k]));
      check($sformatf("%s rpc c%0d", name, k), rpc, e_rpc[k]);
      check($sformatf("%s hold c%0d", name, k), 64'(hold), 64'(e_hold[k]));
    end
  endtask

  task automatic clear_inputs();
    pc = 0; jpc = 0; mstatus = 0; mtvec = 0; mepc = 0;
    jump = 0; expt = 0; inst = 0; irq = 0; mie = 0;
  endtask

  initial begin
    logic [63:0] causes[2];
    int          ncause;

    clear_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst wen", 64'(csr_wen), 0);
    check("rst addr", 64'(csr_waddr), 0);
    check("rst data", csr_wdata, 0);
    check("rst rv", 64'(rv), 0);
    check("rst rpc", rpc, 0);
    check("rst hold", 64'(hold), 0);
    rst_n = 1;
    @(negedge clk); #1;
    check("post-rst hold", 64'(hold), 0);

    // ecall, direct mtvec
    @(negedge clk);
    pc = 64'h8000_0010; mtvec = 64'h8000_1000; mstatus = 64'h8; expt = 4'b0100;
    run_txn("ecall");

    // vectored MTI
    @(negedge clk);
    clear_inputs();
    mstatus = 64'h8; mie = 3'b001; irq = 3'b001; mtvec = 64'h8000_1001; pc = 64'h8000_0100;
    run_txn("mti_vec");

    // MTI during a jump uses the jump target as mepc
    @(negedge clk);
    clear_inputs();
    mstatus = 64'h8; mie = 3'b001; irq = 3'b001; mtvec = 64'h8000_1000;
    pc = 64'h8000_0100; jump = 1; jpc = 64'h8000_0200;
    run_txn("mti_jump");

    // interrupts globally disabled: nothing happens
    @(negedge clk);
    clear_inputs();
    mstatus = 64'h0; mie = 3'b111; irq = 3'b111; mtvec = 64'h8000_1000;
    run_txn("mti_masked");

    // mret
    @(negedge clk);
    clear_inputs();
    mstatus = 64'h80; mepc = 64'h8000_0044; expt = 4'b0001;
    run_txn("mret");

    // illegal instruction (mtval captured when enabled)
    @(negedge clk);
    clear_inputs();
    mstatus = 64'h8; pc = 64'h8000_0300; inst = 32'hFFFF_FFFF; expt = 4'b1000; mtvec = 64'h8000_2001;
    run_txn("illegal");

    // MEI+MTI+ecall: ecall first, then the still-high MEI is taken
    @(negedge clk);
    clear_inputs();
    mstatus = 64'h8; mie = 3'b111; irq = 3'b101; expt = 4'b0100; pc = 64'h8000_0400;
    mtvec = 64'h8000_1000;
    ncause = 0; causes[0] = 0; causes[1] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) expt = 0;
      #1;
      if (csr_wen && csr_waddr == 12'h342 && ncause < 2) begin
        causes[ncause] = csr_wdata;
        ncause++;
      end
    end
    irq = 0;
    check("prio ncause", 64'(ncause), 2);
    check("prio cause0", causes[0], 64'd11);
    check("prio cause1", causes[1], 64'h8000_0000_0000_000B);
    repeat (8) @(negedge clk);

    // reset while in MSTATUS: nothing further is written or redirected
    clear_inputs();
    pc = 64'h8000_0010; mtvec = 64'h8000_1000; mstatus = 64'h8; expt = 4'b0100;
    @(negedge clk); expt = 0;
    @(negedge clk); #1;
    check("midrst mepc wen", 64'(csr_wen), 1);
    check("midrst mepc addr", 64'(csr_waddr), 64'h341);
    rst_n = 0;
    @(negedge clk); #1;
    check("midrst wen c3", 64'(csr_wen), 0);
    check("midrst rv c3", 64'(rv), 0);
    rst_n = 1;
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk); #1;
      check($sformatf("midrst wen c%0d", k), 64'(csr_wen), 0);
      check($sformatf("midrst rv c%0d", k), 64'(rv), 0);
      check($sformatf("midrst hold c%0d", k), 64'(hold), 0);
    end

    // randomized transactions
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      pc      = {$urandom, $urandom};
      jpc     = {$urandom, $urandom};
      mstatus = {$urandom, $urandom};
      mtvec   = {$urandom, $urandom};
      mepc    = {$urandom, $urandom};
      inst    = $urandom;
      jump    = 1'($urandom_range(0, 1));
      irq     = 3'($urandom_range(0, 7));
      mie     = 3'($urandom_range(0, 7));
      expt    = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      run_txn($sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
